// File: rtl/alu_share_arbiter.sv
// Two-port arbiter time-sharing one combinational ALU: grant, drive ALU for one cycle,
// then hold the captured response until the owning port accepts it.
module alu_share_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_ctrl,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_ctrl,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic [3:0]  rsp0_flags,
  output logic        rsp0_err,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [3:0]  rsp1_flags,
  output logic        rsp1_err,

  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,

  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_n,
  input  logic        alu_v,
  input  logic        alu_c
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  flags_q, flags_d;
  logic        err_q, err_d;

  logic gnt_valid;
  logic gnt_id;
  logic owner_rsp_ready;

  function automatic logic ctrl_legal(input logic [3:0] c);
    logic ok;
    case (c)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0101, 4'b0110, 4'b1001, 4'b1010: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Grant only exists in idle and out of reset; on contention pick the port not served last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state_q == StIdle && !rst) begin
      if (req0_valid && req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = RR_EN ? ~last_q : 1'b0;
      end else if (req0_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
  end

  assign req0_ready      = gnt_valid && !gnt_id;
  assign req1_ready      = gnt_valid && gnt_id;
  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    res_d    = res_q;
    flags_d  = flags_q;
    err_d    = err_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          state_d = StExec;
          owner_d = gnt_id;
          last_d  = gnt_id;
          a_d     = gnt_id ? req1_a    : req0_a;
          b_d     = gnt_id ? req1_b    : req0_b;
          ctrl_d  = gnt_id ? req1_ctrl : req0_ctrl;
        end
      end
      StExec: begin
        alu_a    = a_q;
        alu_b    = b_q;
        alu_ctrl = ctrl_q;
        state_d  = StResp;
        // Illegal codes ignore whatever the ALU returns.
        if (ctrl_legal(ctrl_q)) begin
          res_d   = alu_result;
          flags_d = {alu_zero, alu_n, alu_v, alu_c};
          err_d   = 1'b0;
        end else begin
          res_d   = '0;
          flags_d = '0;
          err_d   = 1'b1;
        end
      end
      StResp: begin
        if (owner_rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign rsp0_valid  = (state_q == StResp) && !owner_q;
  assign rsp1_valid  = (state_q == StResp) && owner_q;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_flags  = flags_q;
  assign rsp1_flags  = flags_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;

endmodule
